fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of `imem`. It owns the program counter and drives `imem`'s word address. It pairs each registered `imem` read with the PC that produced it and presents a valid/stall-qualified instruction to decode. It absorbs `imem`'s one-cycle read latency, holds the current instruction across decode stalls, and redirects to branch/jump targets without a bubble.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: PC geometry, reset vector and the fetch FSM encoding.
// imem sizes its array from IMEM_DEPTH so both sides agree on the address space.
package cpu_pkg;

  localparam int PC_W       = 8;
  localparam int RESET_PC   = 0;
  localparam int IMEM_DEPTH = 1 << PC_W;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem word address and pairs
// each registered imem read with the PC that produced it.
module fetch_unit #(
  parameter int PC_W     = cpu_pkg::PC_W,
  parameter int RESET_PC = cpu_pkg::RESET_PC,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  output logic [CNT_W-1:0]  fetch_count
);

  import cpu_pkg::*;

  localparam logic [PC_W-1:0]  RST_PC  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_inst_pc;
  logic [CNT_W-1:0] r_fetch_count;
  logic [PC_W-1:0]  w_sel_pc;
  logic             w_consume;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Fetch FSM next state: BOOT lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Address select. In BOOT nothing is held yet, so the reset vector in
  // r_inst_pc is (re)fetched and stall is ignored; a redirect still wins.
  always_comb begin
    w_sel_pc = r_pc;
    if (!reset_n) begin
      w_sel_pc = RST_PC;
    end else if (redirect) begin
      w_sel_pc = redirect_pc;
    end else if (r_state == BOOT) begin
      w_sel_pc = r_inst_pc;
    end else if (stall) begin
      w_sel_pc = r_inst_pc;
    end else begin
      w_sel_pc = r_pc;
    end
  end

  // Consumed-instruction detection and counter increment.
  always_comb begin
    w_consume = (r_state == RUN) && (!stall || redirect);
    w_cnt_nxt = r_fetch_count;
    if (w_consume) begin
      w_cnt_nxt = r_fetch_count + CNT_ONE;
    end else begin
      w_cnt_nxt = r_fetch_count;
    end
  end

  // Fetch state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, in-flight address and delivered-instruction counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RST_PC + PC_ONE;
      r_inst_pc     <= RST_PC;
      r_fetch_count <= {CNT_W{1'b0}};
    end else begin
      r_pc          <= w_sel_pc + PC_ONE;
      r_inst_pc     <= w_sel_pc;
      r_fetch_count <= w_cnt_nxt;
    end
  end

  assign imem_addr   = {{(32-PC_W){1'b0}}, w_sel_pc};
  assign inst        = imem_data;
  assign inst_pc     = r_inst_pc;
  assign inst_valid  = (r_state == RUN);
  assign fetch_count = r_fetch_count;

endmodule
